// File: rtl/exec_ld_ixd_pkg.sv
// Shared definitions for the LD r,(IX/IY+d) / LD (IX/IY+d),r execution stage:
// FSM encoding, Z80 register codes, flag bit order and decoded-flag record.
package exec_ld_ixd_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH_D = 3'd1;
  localparam logic [2:0] ST_CALC    = 3'd2;
  localparam logic [2:0] ST_MEM     = 3'd3;
  localparam logic [2:0] ST_FIN     = 3'd4;

  localparam logic [2:0] REG_B = 3'd0;
  localparam logic [2:0] REG_C = 3'd1;
  localparam logic [2:0] REG_D = 3'd2;
  localparam logic [2:0] REG_E = 3'd3;
  localparam logic [2:0] REG_H = 3'd4;
  localparam logic [2:0] REG_L = 3'd5;
  localparam logic [2:0] REG_A = 3'd7;

  localparam int IDX_B    = 0;
  localparam int IDX_C    = 1;
  localparam int IDX_D    = 2;
  localparam int IDX_E    = 3;
  localparam int IDX_H    = 4;
  localparam int IDX_L    = 5;
  localparam int IDX_A    = 6;
  localparam int NUM_REGS = 7;

  localparam int CALC_WAIT_DEF = 5;

  typedef struct packed {
    logic       valid;     // exactly one flag high
    logic       multi;     // two or more flags high
    logic       is_y;
    logic       is_store;
    logic [2:0] code;
  } ixd_dec_t;

  // One-hot B..A index to Z80 register code; A skips over the (HL) slot 6.
  function automatic logic [2:0] reg_code(input logic [NUM_REGS-1:0] oh);
    logic [2:0] c;
    c = REG_B;
    for (int i = 0; i < NUM_REGS; i++)
      if (oh[i]) c = (i == IDX_A) ? REG_A : 3'(i);
    return c;
  endfunction

endpackage

// File: rtl/exec_ld_ixd_if.sv
// Memory bus between the execution stage (master) and memory (slave).
interface exec_ld_ixd_if #(parameter int ADDR_W = 16);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ready;

  modport master (output mem_addr, mem_rd, mem_wr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_addr, mem_rd, mem_wr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/exec_ld_ixd_flag_encoder.sv
// Collapses the 28 one-hot decoder flags into valid/multi/index/direction/register code.
module ixd_flag_encoder
  import exec_ld_ixd_pkg::*;
(
  input  logic [NUM_REGS-1:0] i_set_ld_r_x,
  input  logic [NUM_REGS-1:0] i_set_ld_m_x,
  input  logic [NUM_REGS-1:0] i_set_ld_r_y,
  input  logic [NUM_REGS-1:0] i_set_ld_m_y,
  output ixd_dec_t            o_dec
);

  logic [4*NUM_REGS-1:0] w_flags;
  logic [4:0]            w_cnt;
  logic [NUM_REGS-1:0]   w_oh;

  always_comb begin
    w_flags = {i_set_ld_m_y, i_set_ld_r_y, i_set_ld_m_x, i_set_ld_r_x};
    w_cnt   = '0;
    for (int i = 0; i < 4 * NUM_REGS; i++)
      w_cnt = w_cnt + 5'(w_flags[i]);
    // Register index is only meaningful when valid, so OR-ing the groups is safe.
    w_oh           = i_set_ld_r_x | i_set_ld_m_x | i_set_ld_r_y | i_set_ld_m_y;
    o_dec.valid    = (w_cnt == 5'd1);
    o_dec.multi    = (w_cnt > 5'd1);
    o_dec.is_y     = |(i_set_ld_r_y | i_set_ld_m_y);
    o_dec.is_store = |(i_set_ld_m_x | i_set_ld_m_y);
    o_dec.code     = reg_code(w_oh);
  end

endmodule

// File: rtl/exec_ld_ixd.sv
// Executes LD r,(IX/IY+d) and LD (IX/IY+d),r: fetch d, form EA, one bus
// access, optional register write-back, done pulse.
module exec_ld_ixd
  import exec_ld_ixd_pkg::*;
#(
  parameter int CALC_WAIT = CALC_WAIT_DEF,
  parameter int ADDR_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REGS-1:0] i_set_ld_r_x,
  input  logic [NUM_REGS-1:0] i_set_ld_m_x,
  input  logic [NUM_REGS-1:0] i_set_ld_r_y,
  input  logic [NUM_REGS-1:0] i_set_ld_m_y,
  input  logic [ADDR_W-1:0]   i_ix,
  input  logic [ADDR_W-1:0]   i_iy,
  input  logic [ADDR_W-1:0]   i_pc,
  output logic                o_pc_inc,
  exec_ld_ixd_if.master       bus,
  output logic [2:0]          o_reg_rsel,
  input  logic [7:0]          i_reg_rdata,
  output logic                o_reg_we,
  output logic [2:0]          o_reg_wsel,
  output logic [7:0]          o_reg_wdata,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  localparam logic [3:0] CALC_LAST = 4'(CALC_WAIT - 1);

  ixd_dec_t          w_dec;
  logic [2:0]        r_state;
  logic              r_is_y;
  logic              r_is_store;
  logic [2:0]        r_code;
  logic [7:0]        r_d;
  logic [ADDR_W-1:0] r_ea;
  logic [7:0]        r_wdata;
  logic [7:0]        r_ldata;
  logic [3:0]        r_cnt;
  logic              r_pc_inc;
  logic              r_err;
  logic [ADDR_W-1:0] w_base;

  ixd_flag_encoder u_enc (
    .i_set_ld_r_x (i_set_ld_r_x),
    .i_set_ld_m_x (i_set_ld_m_x),
    .i_set_ld_r_y (i_set_ld_r_y),
    .i_set_ld_m_y (i_set_ld_m_y),
    .o_dec        (w_dec)
  );

  assign w_base = r_is_y ? i_iy : i_ix;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_is_y     <= 1'b0;
      r_is_store <= 1'b0;
      r_code     <= '0;
      r_d        <= '0;
      r_ea       <= '0;
      r_wdata    <= '0;
      r_ldata    <= '0;
      r_cnt      <= '0;
      r_pc_inc   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_pc_inc <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        // FIN doubles as an accept slot so back-to-back instructions keep busy high.
        ST_IDLE, ST_FIN: begin
          r_err <= (r_state == ST_IDLE) && w_dec.multi;
          if (w_dec.valid) begin
            r_is_y     <= w_dec.is_y;
            r_is_store <= w_dec.is_store;
            r_code     <= w_dec.code;
            r_state    <= ST_FETCH_D;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_FETCH_D: begin
          if (bus.mem_ready) begin
            r_d      <= bus.mem_rdata;
            r_pc_inc <= 1'b1;
            r_cnt    <= '0;
            r_state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (r_cnt == '0)
            r_ea <= w_base + {{(ADDR_W-8){r_d[7]}}, r_d};
          if (r_cnt == CALC_LAST) begin
            if (r_is_store) r_wdata <= i_reg_rdata;
            r_state <= ST_MEM;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_MEM: begin
          if (bus.mem_ready) begin
            if (!r_is_store) r_ldata <= bus.mem_rdata;
            r_state <= ST_FIN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_wdata = '0;
    o_reg_rsel    = '0;
    o_reg_we      = 1'b0;
    o_reg_wsel    = '0;
    o_reg_wdata   = '0;
    case (r_state)
      ST_FETCH_D: begin
        bus.mem_addr = i_pc;
        bus.mem_rd   = 1'b1;
      end
      ST_CALC: o_reg_rsel = r_code;
      ST_MEM: begin
        bus.mem_addr = r_ea;
        bus.mem_rd   = !r_is_store;
        bus.mem_wr   = r_is_store;
        if (r_is_store) bus.mem_wdata = r_wdata;
      end
      ST_FIN: begin
        if (!r_is_store) begin
          o_reg_we    = 1'b1;
          o_reg_wsel  = r_code;
          o_reg_wdata = r_ldata;
        end
      end
      default: ;
    endcase
  end

  assign o_busy   = (r_state != ST_IDLE);
  assign o_done   = (r_state == ST_FIN);
  assign o_pc_inc = r_pc_inc;
  assign o_err    = r_err;

endmodule
